// File: rtl/uart_pkg.sv
// Shared UART constants and types.
// Used by the receive FIFO and its storage array.
package uart_pkg;

    localparam int CLOCK_FREQ      = 50_000_000;
    localparam int BAUD_RATE       = 115_200;
    localparam int BAUD_TICKS      = CLOCK_FREQ / BAUD_RATE;
    localparam int UART_FIFO_DEPTH = 32;

    typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the receive FIFO.
// One synchronous write port, one combinational read port.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter  int DEPTH  = UART_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  uart_byte_t        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output uart_byte_t        o_rdata
);

    uart_byte_t r_mem [DEPTH];

    // Storage is never cleared; contents only matter where the pointers say so.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: FWFT output, drop-on-full with sticky overflow.
// Optional byte statistics under UART_RX_FIFO_STATS_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH  = UART_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  uart_byte_t      in_data,
    input  logic            in_valid,
    output uart_byte_t      out_data,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic            flush,
    output logic [ADDR_W:0] count,
    output logic            full,
    output logic            overflow,
    input  logic            ovf_clr,
    output logic [15:0]     rx_bytes,
    output logic [7:0]      drop_bytes
);

    localparam logic [ADDR_W:0] PTR_ONE = 1;

    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic [ADDR_W:0] r_count;
    logic            r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_we;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_pop   = ~w_empty & out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push  = in_valid & (~w_full | w_pop);
    assign w_drop  = in_valid & w_full & ~w_pop;
    assign w_we    = w_push & ~flush;

    uart_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (out_data)
    );

    // Pointers, occupancy and sticky overflow; flush overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + PTR_ONE;
                2'b01:   r_count <= r_count - PTR_ONE;
                default: r_count <= r_count;
            endcase
            // A new drop wins over a clear in the same cycle.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign out_valid = ~w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;

`ifdef UART_RX_FIFO_STATS_EN
    logic [15:0] r_rx_bytes;
    logic [7:0]  r_drop_bytes;

    // Lifetime counters; only reset clears them, flush does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_bytes   <= '0;
            r_drop_bytes <= '0;
        end else if (!flush) begin
            if (w_push) begin
                r_rx_bytes <= r_rx_bytes + 16'd1;
            end
            if (w_drop && (r_drop_bytes != 8'hFF)) begin
                r_drop_bytes <= r_drop_bytes + 8'd1;
            end
        end
    end

    assign rx_bytes   = r_rx_bytes;
    assign drop_bytes = r_drop_bytes;
`else
    assign rx_bytes   = '0;
    assign drop_bytes = '0;
`endif

endmodule
